// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM data ports.
// Optional 1-entry fetch buffer enabled by ARB_FETCH_BUF_EN.
module mem_port_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_re,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        DM_ACC
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic          flush_q;
    logic          if_rdy_q;
    logic          dm_rdy_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;

    logic          dm_pend;
    logic          if_pend;
    logic          grant_dm;
    logic          grant_if;
    logic          buf_take;
    logic          buf_hit;
    logic [DW-1:0] hit_data;
    logic          done_if;
    logic          done_dm;
    logic          if_kill;

    // A requester still holds its request during its ready cycle; mask it.
    assign dm_pend = (dm_re | dm_we) & ~dm_rdy_q;
    assign if_pend = if_req & ~if_rdy_q;

    assign done_if = (state_q == IF_ACC) && (cnt_q == 4'd0);
    assign done_dm = (state_q == DM_ACC) && (cnt_q == 4'd0);
    assign if_kill = flush_q | if_flush;

    always_comb begin
        state_d  = state_q;
        grant_dm = 1'b0;
        grant_if = 1'b0;
        buf_take = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dm_pend) begin
                    state_d  = DM_ACC;
                    grant_dm = 1'b1;
                end else if (if_pend && buf_hit) begin
                    buf_take = 1'b1;
                end else if (if_pend) begin
                    state_d  = IF_ACC;
                    grant_if = 1'b1;
                end
            end
            IF_ACC, DM_ACC: begin
                if (cnt_q == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            flush_q    <= 1'b0;
            if_rdy_q   <= 1'b0;
            dm_rdy_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            if_rdy_q <= (done_if && !if_kill) || buf_take;
            dm_rdy_q <= done_dm;
            flush_q  <= (state_q == IF_ACC) && !done_if && if_kill;
            if (grant_dm || grant_if) begin
                addr_q  <= grant_dm ? dm_addr : if_addr;
                wdata_q <= dm_wdata;
                we_q    <= grant_dm && dm_we;
                cnt_q   <= CNT_INIT;
            end else if (state_q != IDLE && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (done_if && !if_kill) begin
                if_rdata_q <= mem_rdata;
            end else if (buf_take) begin
                if_rdata_q <= hit_data;
            end
            if (done_dm && !we_q) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef ARB_FETCH_BUF_EN
    logic          buf_valid_q;
    logic [AW-1:0] buf_addr_q;
    logic [DW-1:0] buf_data_q;

    assign buf_hit  = buf_valid_q && (buf_addr_q == if_addr);
    assign hit_data = buf_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else if (done_if && !if_kill) begin
            buf_valid_q <= 1'b1;
            buf_addr_q  <= addr_q;
            buf_data_q  <= mem_rdata;
        end else if (grant_dm && dm_we && (dm_addr == buf_addr_q)) begin
            buf_valid_q <= 1'b0;
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign hit_data = '0;
`endif

    assign mem_en    = (state_q != IDLE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign if_ready  = if_rdy_q;
    assign dm_ready  = dm_rdy_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule
